ni_rx_fifo_sink: RTL and testbench

Receive-side network interface stage that sits directly downstream of the router ejection port, which is also where `source_from_memory` traffic lands. It accepts flits over the `req`/`busy` handshake and drops flits whose destination field does not match its `id`. Accepted flits are buffered in a small FIFO and presented to the local consumer over a `valid`/`ready` interface. The stage keeps saturating receive, drop and end-of-message statistics.

---
 rtl/ni_rx_fifo_sink_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/ni_rx_fifo_sink.sv | 81 ++++++++
 tb/tb_ni_rx_fifo_sink.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ni_rx_fifo_sink_pkg.sv
// Shared flit layout, FIFO entry layout and small helper functions for the RX sink.
// Field widths follow the NoC defines; defaults below apply only when the shared header is absent.
// Pure declarations; no logic, no latency, no flow control.
`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif

package ni_rx_fifo_sink_pkg;

  localparam int HDR_W   = `HDR_SZ;
  localparam int PL_W    = `PL_SZ;
  localparam int ADDR_W  = `ADDR_SZ;
  localparam int FLIT_W  = HDR_W + PL_W + ADDR_W;
  localparam int ENTRY_W = HDR_W + PL_W;

  // Flit as it arrives from the router ejection port: {source, payload, destination}.
  typedef struct packed {
    logic [HDR_W-1:0]  src;
    logic [PL_W-1:0]   payload;
    logic [ADDR_W-1:0] dest;
  } flit_t;

  // What the FIFO keeps: destination is consumed by the filter and not stored.
  typedef struct packed {
    logic [HDR_W-1:0] src;
    logic [PL_W-1:0]  payload;
  } entry_t;

  // A node id of -1 disables filtering; otherwise destination must equal the node id.
  function automatic logic dest_match(input logic [ADDR_W-1:0] dest, input int node_id);
    return (node_id == -1) || (dest == ADDR_W'(node_id));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and registered full/empty flags.
// Latency: a push at edge k is visible at the head after edge k; no same-cycle fall-through.
// Backpressure: push is ignored while full, pop is ignored while empty; flags come from next-state count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic [PW:0]      cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers, occupancy and flags; flags are flopped from next-state occupancy so they never lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (PW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage write; contents need no reset because the head is only meaningful when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ni_rx_fifo_sink.sv
// RX network interface: filters ejected flits by destination, buffers them, hands them to the local consumer.
// Latency: accepted flit reaches the head outputs one cycle after the accepting edge.
// Backpressure: registered busy while FIFO full; offers during busy are ignored; dropped flits never stall.
module ni_rx_fifo_sink
  import ni_rx_fifo_sink_pkg::*;
#(
  parameter int            id    = -1,
  parameter int            DEPTH = 4,
  parameter logic [PL_W-1:0] EOM = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] data,
  input  logic              req,
  output logic              busy,
  output logic [HDR_W-1:0]  out_src,
  output logic [PL_W-1:0]   out_payload,
  output logic              out_eom,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       rx_cnt,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        msg_cnt
);

  flit_t  flit;
  entry_t push_entry;
  entry_t head_raw;
  entry_t head;
  logic   offer;
  logic   keep;
  logic   push;
  logic   drop;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;

  assign flit       = flit_t'(data);
  assign offer      = req & ~busy;
  assign keep       = dest_match(flit.dest, id);
  assign push       = offer & keep;
  assign drop       = offer & ~keep;
  assign pop        = out_valid & out_ready;
  assign push_entry = '{src: flit.src, payload: flit.payload};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head is forced to zero while empty so an idle or freshly reset port reads clean values.
  assign head        = out_valid ? head_raw : '0;
  assign busy        = fifo_full;
  assign out_valid   = ~fifo_empty;
  assign out_src     = head.src;
  assign out_payload = head.payload;
  assign out_eom     = (head.payload == EOM);

  // Saturating receive, drop and end-of-message statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
      msg_cnt  <= '0;
    end else begin
      if (push)           rx_cnt   <= sat_inc16(rx_cnt);
      if (drop)           drop_cnt <= sat_inc8(drop_cnt);
      if (pop && out_eom) msg_cnt  <= sat_inc8(msg_cnt);
    end
  end

endmodule

// File: tb/tb_ni_rx_fifo_sink.sv
// Directed bench for ni_rx_fifo_sink: filtered instance (id=3) and unfiltered instance (id=-1).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Each check is counted; mismatches print a FAIL line, then one summary line at the end.
module tb_ni_rx_fifo_sink;
  import ni_rx_fifo_sink_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] data;
  logic              req, req_b;
  logic              out_ready, out_ready_b;

  logic              busy, out_eom, out_valid;
  logic [HDR_W-1:0]  out_src;
  logic [PL_W-1:0]   out_payload;
  logic [15:0]       rx_cnt;
  logic [7:0]        drop_cnt, msg_cnt;

  logic              b_busy, b_out_eom, b_out_valid;
  logic [HDR_W-1:0]  b_out_src;
  logic [PL_W-1:0]   b_out_payload;
  logic [15:0]       b_rx_cnt;
  logic [7:0]        b_drop_cnt, b_msg_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ni_rx_fifo_sink #(.id(3), .DEPTH(4), .EOM(8'h00)) dut (
    .clk(clk), .reset(reset), .data(data), .req(req), .busy(busy),
    .out_src(out_src), .out_payload(out_payload), .out_eom(out_eom),
    .out_valid(out_valid), .out_ready(out_ready),
    .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .msg_cnt(msg_cnt)
  );

  ni_rx_fifo_sink #(.id(-1), .DEPTH(4), .EOM(8'h00)) dut_b (
    .clk(clk), .reset(reset), .data(data), .req(req_b), .busy(b_busy),
    .out_src(b_out_src), .out_payload(b_out_payload), .out_eom(b_out_eom),
    .out_valid(b_out_valid), .out_ready(out_ready_b),
    .rx_cnt(b_rx_cnt), .drop_cnt(b_drop_cnt), .msg_cnt(b_msg_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk(input int src, input int pl, input int dest);
    flit_t f;
    f.src     = HDR_W'(src);
    f.payload = PL_W'(pl);
    f.dest    = ADDR_W'(dest);
    return f;
  endfunction

  initial begin
    reset = 1'b1; req = 1'b0; req_b = 1'b0; out_ready = 1'b0; out_ready_b = 1'b0;
    data = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rx", 32'(rx_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_msg", 32'(msg_cnt), 0);
    chk("rst_payload", 32'(out_payload), 0);

    // Basic accept: visible one cycle after the accepting edge
    data = mk(1, 8'h41, 3); req = 1'b1;
    step();
    req = 1'b0;
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_payload", 32'(out_payload), 32'h41);
    chk("basic_src", 32'(out_src), 1);
    chk("basic_eom", 32'(out_eom), 0);
    chk("basic_rx", 32'(rx_cnt), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("basic_popped", 32'(out_valid), 0);
    chk("basic_msg", 32'(msg_cnt), 0);

    // Filter: dest 2 dropped by id=3, accepted by id=-1
    data = mk(5, 8'h77, 2); req = 1'b1; req_b = 1'b1;
    step();
    req = 1'b0; req_b = 1'b0;
    chk("filt_valid", 32'(out_valid), 0);
    chk("filt_drop", 32'(drop_cnt), 1);
    chk("filt_rx", 32'(rx_cnt), 1);
    chk("all_valid", 32'(b_out_valid), 1);
    chk("all_payload", 32'(b_out_payload), 32'h77);
    chk("all_src", 32'(b_out_src), 5);
    chk("all_rx", 32'(b_rx_cnt), 1);
    chk("all_drop", 32'(b_drop_cnt), 0);
    out_ready_b = 1'b1;

    // Full/backpressure: six offers held, only four accepted
    req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = mk(2, 8'h10 + i, 3);
      step();
      if (i == 2) chk("full_busy_low", 32'(busy), 0);
      if (i == 3) chk("full_busy_high", 32'(busy), 1);
    end
    req = 1'b0;
    chk("full_busy_hold", 32'(busy), 1);
    chk("full_rx", 32'(rx_cnt), 5);
    chk("full_drop", 32'(drop_cnt), 1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_payload", 32'(out_payload), 32'h10 + j);
      step();
      if (j == 0) chk("drain_busy_fall", 32'(busy), 0);
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 0);

    // Simultaneous push+pop at occupancy 2
    req = 1'b1;
    data = mk(3, 8'h20, 3); step();
    data = mk(3, 8'h21, 3); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = mk(3, 8'h22 + i, 3);
      chk("sim_order", 32'(out_payload), 32'h20 + i);
      chk("sim_busy", 32'(busy), 0);
      step();
    end
    req = 1'b0;
    chk("sim_head0", 32'(out_payload), 32'h2A);
    step();
    chk("sim_head1", 32'(out_payload), 32'h2B);
    step();
    out_ready = 1'b0;
    chk("sim_empty", 32'(out_valid), 0);
    chk("sim_rx", 32'(rx_cnt), 17);

    // Reset mid-stream with a req present in the reset cycle
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = mk(4, 8'h40 + i, 3);
      step();
    end
    data = mk(4, 8'h43, 3);
    reset = 1'b1;
    step();
    reset = 1'b0; req = 1'b0;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_rx", 32'(rx_cnt), 0);
    chk("mrst_drop", 32'(drop_cnt), 0);
    chk("mrst_msg", 32'(msg_cnt), 0);
    data = mk(6, 8'h55, 3); req = 1'b1;
    step();
    req = 1'b0;
    chk("mrst_next_valid", 32'(out_valid), 1);
    chk("mrst_next_payload", 32'(out_payload), 32'h55);
    chk("mrst_next_rx", 32'(rx_cnt), 1);
    out_ready = 1'b1;
    step();
    chk("mrst_next_popped", 32'(out_valid), 0);

    // EOM counting and saturation of msg_cnt and rx_cnt
    data = mk(7, 8'h00, 3); req = 1'b1; out_ready = 1'b1;
    for (int n = 1; n <= 70000; n++) begin
      step();
      if (n == 255) chk("msg_254", 32'(msg_cnt), 254);
      if (n == 300) begin
        chk("msg_sat", 32'(msg_cnt), 255);
        chk("eom_head", 32'(out_eom), 1);
        chk("rx_301", 32'(rx_cnt), 301);
        chk("stream_busy", 32'(busy), 0);
      end
    end
    req = 1'b0;
    chk("rx_sat", 32'(rx_cnt), 32'hFFFF);
    chk("msg_hold", 32'(msg_cnt), 255);
    chk("drop_final", 32'(drop_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
